// File: rtl/rotfpga_pkg.sv
// Shared types and constants for the rotating-tile FPGA scan loader.
package rotfpga_pkg;

  localparam int SCAN_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/rotfpga_rb_deser.sv
// LSB-first readback deserializer: one byte out per eight samples.
module rotfpga_rb_deser
  import rotfpga_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   sample,
  input  logic                   sdi,
  output logic [SCAN_BYTE_W-1:0] data,
  output logic                   valid
);

  localparam int CW = $clog2(SCAN_BYTE_W);

  logic [SCAN_BYTE_W-1:0] sr;
  logic [CW-1:0]          cnt;
  logic [SCAN_BYTE_W-1:0] nxt;

  assign nxt = {sdi, sr[SCAN_BYTE_W-1:1]};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr    <= '0;
      cnt   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (sample) begin
        sr  <= nxt;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(SCAN_BYTE_W - 1)) begin
          data  <= nxt;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rotfpga_scan_loader.sv
// Bitstream loader: streams bytes LSB-first into the fabric scan chain,
// collects the displaced chain contents as readback, then latches.
module rotfpga_scan_loader
  import rotfpga_pkg::*;
#(
  parameter int CHAIN_LEN = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       scan_en,
  output logic       scan_out,
  input  logic       scan_in,
  output logic       cfg_latch,
  output logic [7:0] rb_data,
  output logic       rb_valid,
  output logic       busy,
  output logic       done
);

  localparam int NBYTES = CHAIN_LEN / SCAN_BYTE_W;
  localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
  localparam int ACC_W  = $clog2(NBYTES + 1);

  scan_state_t      state;
  logic [CNT_W-1:0] bit_cnt;
  logic [ACC_W-1:0] acc_cnt;
  logic [7:0]       byte_q;
  logic [2:0]       bit_idx;
  logic             accept;
  logic             last_bit;
  logic             load_start;

  // scan_en doubles as "a byte is held": it is high exactly on bit cycles.
  assign in_ready = (state == ST_SHIFT)
                 && (!scan_en || bit_idx == 3'd7)
                 && (acc_cnt < ACC_W'(NBYTES));

  assign accept     = in_valid && in_ready;
  assign last_bit   = scan_en && (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign load_start = (state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      acc_cnt   <= '0;
      byte_q    <= '0;
      bit_idx   <= '0;
      scan_en   <= 1'b0;
      scan_out  <= 1'b0;
      cfg_latch <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cfg_latch <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SHIFT;
            busy    <= 1'b1;
            bit_cnt <= '0;
            acc_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (scan_en)
            bit_cnt <= bit_cnt + 1'b1;
          if (accept) begin
            scan_en  <= 1'b1;
            scan_out <= in_data[0];
            byte_q   <= in_data;
            bit_idx  <= '0;
            acc_cnt  <= acc_cnt + 1'b1;
          end else if (scan_en && bit_idx != 3'd7) begin
            bit_idx  <= bit_idx + 3'd1;
            scan_out <= byte_q[bit_idx + 3'd1];
          end else begin
            scan_en <= 1'b0;
          end
          if (last_bit) begin
            state     <= ST_LATCH;
            cfg_latch <= 1'b1;
          end
        end
        ST_LATCH: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rotfpga_rb_deser u_deser (
    .clk    (clk),
    .rst    (rst),
    .clr    (load_start),
    .sample (scan_en),
    .sdi    (scan_in),
    .data   (rb_data),
    .valid  (rb_valid)
  );

endmodule

// File: tb/tb_rotfpga_scan_loader.sv
// Bench for rotfpga_scan_loader: 16-bit chain model plus bit/readback scoreboards.
module tb_rotfpga_scan_loader;

  localparam int CL = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       scan_en;
  logic       scan_out;
  logic       scan_in;
  logic       cfg_latch;
  logic [7:0] rb_data;
  logic       rb_valid;
  logic       busy;
  logic       done;

  rotfpga_scan_loader #(.CHAIN_LEN(CL)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .scan_en   (scan_en),
    .scan_out  (scan_out),
    .scan_in   (scan_in),
    .cfg_latch (cfg_latch),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // fabric chain: head at bit 15, tail at bit 0
  logic [CL-1:0] chain = 16'hC3E1;
  always @(posedge clk)
    if (scan_en) chain <= {scan_out, chain[CL-1:1]};
  assign scan_in = chain[0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  logic       exp_bits[$];
  logic [7:0] exp_rb[$];

  int en_total = 0;
  int rb_total = 0;
  int latch_total = 0;
  int done_total = 0;
  int last_en_cyc = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (scan_en) begin
      if (exp_bits.size() == 0) chk("bit_underflow", 1, 0);
      else chk("scan_out", scan_out, exp_bits.pop_front());
      en_total++;
      last_en_cyc = cyc;
    end
    if (rb_valid) begin
      if (exp_rb.size() == 0) chk("rb_underflow", 1, 0);
      else chk("rb_data", rb_data, exp_rb.pop_front());
      rb_total++;
    end
    if (cfg_latch) begin
      chk("latch_t", cyc, last_en_cyc + 1);
      chk("latch_rb", rb_valid, 1);
      chk("latch_en", scan_en, 0);
      latch_total++;
    end
    if (done) begin
      chk("done_t", cyc, last_en_cyc + 2);
      chk("done_busy", busy, 0);
      done_total++;
      done_cyc = cyc;
    end
  end

  task automatic zero_outs(input string tag);
    chk({tag, "_rdy"}, in_ready, 0);
    chk({tag, "_en"}, scan_en, 0);
    chk({tag, "_so"}, scan_out, 0);
    chk({tag, "_lat"}, cfg_latch, 0);
    chk({tag, "_rbd"}, rb_data, 0);
    chk({tag, "_rbv"}, rb_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // present one byte after gap ready-cycles with in_valid low
  task automatic put(input logic [7:0] b, input int gap);
    int g;
    int t;
    g = gap;
    t = 0;
    in_data = b;
    while (1) begin
      in_valid = (g == 0);
      if (in_ready && in_valid) begin
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        @(negedge clk);
        break;
      end
      if (in_ready) g--;
      @(negedge clk);
      t++;
      if (t > 200) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_done(input int base);
    int t;
    t = 0;
    while (done_total == base && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (done_total == base) chk("done_timeout", 0, 1);
  endtask

  task automatic run_load(input logic [7:0] b0,
                          input logic [7:0] b1,
                          input int gap,
                          input bit mid_start);
    int e0, r0, l0, d0, sc;
    e0 = en_total;
    r0 = rb_total;
    l0 = latch_total;
    d0 = done_total;
    exp_rb.push_back(chain[7:0]);
    exp_rb.push_back(chain[15:8]);
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    sc = cyc;
    @(negedge clk);
    start = 1'b0;
    fork
      begin
        put(b0, 0);
        put(b1, gap);
        in_valid = 1'b0;
      end
      begin
        if (mid_start) begin
          repeat (5) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    wait_done(d0);
    chk("latency", done_cyc - sc, CL + 3 + gap);
    chk("chain", chain, {b1, b0});
    chk("en_cnt", en_total - e0, CL);
    chk("rb_cnt", rb_total - r0, 2);
    chk("latch_cnt", latch_total - l0, 1);
    chk("bits_left", exp_bits.size(), 0);
    chk("rb_left", exp_rb.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int l0, t;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (2) @(negedge clk);
    zero_outs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy", in_ready, 0);
    chk("idle_busy", busy, 0);
    in_valid = 1'b0;

    run_load(8'hA5, 8'h3C, 0, 1'b0);
    run_load(8'hFF, 8'h00, 0, 1'b0);
    run_load(8'h5A, 8'hC3, 3, 1'b0);
    run_load(8'h96, 8'hE7, 0, 1'b1);

    // reset in the middle of a shift
    l0 = latch_total;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_t1", busy, 1);
    put(8'h77, 0);
    in_valid = 1'b0;
    t = 0;
    while (en_total < 0 + (CL * 4) + 5 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("mid_en_reached", en_total >= CL * 4 + 5, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    zero_outs("mid_rst");
    rst = 1'b0;
    exp_bits.delete();
    exp_rb.delete();
    repeat (4) @(negedge clk);
    chk("no_latch", latch_total - l0, 0);
    chk("idle_after_rst", busy, 0);

    run_load(8'h12, 8'h34, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rotfpga_scan_loader.md
# rotfpga_scan_loader

Bitstream loader and scan-chain sequencer for the rotating-tile FPGA fabric. It accepts configuration bytes over a valid/ready stream and shifts them LSB-first into the fabric scan chain, one bit per clock. It captures the bits leaving the chain tail as readback bytes, then pulses the configuration latch. It sits between the host-facing byte interface and the fabric's scan-enable, scan-in, scan-out and latch pins.

## Interface
- `CHAIN_LEN`, default 512: scan chain length in bits. Must be a multiple of 8 and at least 8.
- `clk` in 1: single clock. Everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a load. Honoured only in IDLE.
- `in_data` in 8: configuration byte. Bit 0 is shifted first.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: byte accepted on an edge where `in_valid && in_ready`.
- `scan_en` out 1: fabric scan enable. The chain shifts on every edge where it is high.
- `scan_out` out 1: bit into the chain head.
- `scan_in` in 1: chain tail bit.
- `cfg_latch` out 1: one-cycle configuration latch strobe.
- `rb_data` out 8: readback byte. The first bit out of the tail is bit 0.
- `rb_valid` out 1: one-cycle qualifier for `rb_data`. There is no backpressure.
- `busy` out 1: high in SHIFT and LATCH.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, SHIFT, LATCH, DONE.
- IDLE -> SHIFT on `start`.
- SHIFT -> LATCH after the final (CHAIN_LEN-th) bit cycle.
- LATCH -> DONE unconditionally.
- DONE -> IDLE unconditionally.
- IDLE:
  - `in_ready`=0.
  - `start` moves to SHIFT and clears the bit counter and readback deserializer.
  - `start` in any other state is ignored.
- SHIFT, byte intake:
  - `in_ready` is combinational: high when no byte is held, or the held byte is on its bit-7 cycle, and fewer than CHAIN_LEN/8 bytes have been accepted.
- SHIFT, bit output:
  - Each accepted byte produces 8 consecutive bit cycles, starting the cycle after acceptance.
  - On each bit cycle `scan_en`=1 and `scan_out`=byte[i], i=0..7 in order.
- SHIFT, stalls:
  - If no byte is held, `scan_en`=0 and all counters hold. No bit is lost or duplicated.
  - Stall length equals the number of cycles `in_valid` was low while `in_ready` was high.
- Readback:
  - `scan_in` is sampled on every edge where `scan_en`=1 and shifted into the deserializer LSB-first.
  - After every 8th sample, `rb_valid`=1 for one cycle, with `rb_data` holding those 8 bits.
  - Exactly CHAIN_LEN/8 readback bytes are produced per load. They are the chain's previous contents, in load order.
- LATCH: `cfg_latch`=1, `scan_en`=0.
- DONE: `done`=1, `busy`=0.
- Bit counter: width $clog2(CHAIN_LEN+1). It counts bit cycles only and never wraps within a load.
- Reset:
  - Every output resets to 0: `in_ready`, `scan_en`, `scan_out`, `cfg_latch`, `rb_data`, `rb_valid`, `busy`, `done`.
  - State returns to IDLE.
  - A partially shifted chain is left as-is. No latch is issued, and software must reload.

## Timing
- `scan_en`, `scan_out`, `cfg_latch`, `rb_valid`, `rb_data`, `busy` and `done` are registered.
- `start` on edge T:
  - `busy`=1 from T+1.
  - `in_ready` may be high from T+1.
- Byte accepted on edge N: bit cycles at N+1..N+8.
- Back-to-back: the next byte is accepted on edge N+8, so `scan_en` runs continuously at 1 bit/clock.
- Final bit cycle F:
  - `rb_valid` for the last byte at F+1.
  - `cfg_latch` at F+1.
  - `done` at F+2.
  - `busy` low at F+2.
- Load latency with no stalls: CHAIN_LEN+3 cycles from `start` to `done`.

## Structure
- Shared package `rotfpga_pkg` holds:
  - state enum `scan_state_t` (IDLE, SHIFT, LATCH, DONE);
  - constant `SCAN_BYTE_W`=8.
- Sub-module `rotfpga_rb_deser`: 8-bit LSB-first deserializer with a sample strobe and a one-cycle valid output. It is cleared by `rst` or `start`.

## Test plan
Benches use CHAIN_LEN=16 and a 16-bit shift-register chain model (tail = `scan_in`).
- Reset: hold `rst` 2 cycles -> every output 0; `in_ready`=0 in IDLE even with `in_valid`=1.
- Continuous load: `start`, then 0xA5 and 0x3C with `in_valid` held -> `scan_out` 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 over 16 contiguous `scan_en` cycles; `cfg_latch` at F+1; `done` at F+2; model holds 0x3CA5.
- Readback: second load of 0xFF,0x00 -> `rb_valid` twice, `rb_data`=0xA5 then 0x3C; model ends 0x00FF.
- Stall: `in_valid` low 3 cycles between bytes -> `scan_en` low exactly 3 cycles; model contents correct; exactly 2 readback bytes.
- Ignored start: `start` pulsed mid-SHIFT -> no restart, bit sequence and `done` timing unchanged.
- Reset mid-shift after 5 bit cycles -> next cycle all outputs 0 and no `cfg_latch`; a following full load of 0x12,0x34 completes correctly.
